// File: rtl/chroma8x8_intra_modesel.sv
// Chroma 8x8 intra mode selection: evaluates DC, Horizontal and Vertical
// prediction by row-serial SAD and returns the best mode, SAD and prediction.
module chroma8x8_intra_modesel #(
    parameter int unsigned SAD_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             top_avail,
    input  logic             left_avail,
    input  logic [511:0]     mb_in,
    input  logic [63:0]      top_in,
    input  logic [63:0]      left_in,
    output logic             busy,
    output logic             valid,
    output logic [1:0]       best_mode,
    output logic [SAD_W-1:0] best_sad,
    output logic [511:0]     pred_out
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    state_t           state_q;
    logic [511:0]     mb_q;
    logic [63:0]      top_q, left_q;
    logic             top_av_q, left_av_q;
    logic [1:0]       mode_q, bm_q;
    logic [2:0]       row_q;
    logic [SAD_W-1:0] acc_q, best_q;
    logic             busy_q, valid_q;
    logic [1:0]       best_mode_q;
    logic [SAD_W-1:0] best_sad_q;
    logic [511:0]     pred_out_q;

    logic [9:0]       st0, st1, sl0, sl1;
    logic [9:0]       h_st0, h_st1, h_sl0, h_sl1;
    logic [10:0]      both0, both1;
    logic [7:0]       dc00, dc10, dc01, dc11;
    logic [1:0]       sel_mode;
    logic [511:0]     pred_blk;
    logic [63:0]      mb_row, pred_row;
    logic [7:0]       pa, pp, diff;
    logic [10:0]      row_sum;
    logic [SAD_W-1:0] sad_d;
    logic             mode_avail;

    // DC quadrant values; dcXY is quadrant (qx = X, qy = Y)
    always_comb begin
        st0 = '0;
        st1 = '0;
        sl0 = '0;
        sl1 = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            st0 = st0 + {2'b00, top_q[8*i +: 8]};
            st1 = st1 + {2'b00, top_q[8*(i+4) +: 8]};
            sl0 = sl0 + {2'b00, left_q[8*i +: 8]};
            sl1 = sl1 + {2'b00, left_q[8*(i+4) +: 8]};
        end
        h_st0 = st0 + 10'd2;
        h_st1 = st1 + 10'd2;
        h_sl0 = sl0 + 10'd2;
        h_sl1 = sl1 + 10'd2;
        both0 = {1'b0, st0} + {1'b0, sl0} + 11'd4;
        both1 = {1'b0, st1} + {1'b0, sl1} + 11'd4;

        if (top_av_q && left_av_q) begin
            dc00 = both0[10:3];
            dc11 = both1[10:3];
        end else if (top_av_q) begin
            dc00 = h_st0[9:2];
            dc11 = h_st1[9:2];
        end else if (left_av_q) begin
            dc00 = h_sl0[9:2];
            dc11 = h_sl1[9:2];
        end else begin
            dc00 = 8'd128;
            dc11 = 8'd128;
        end

        if (top_av_q)       dc10 = h_st1[9:2];
        else if (left_av_q) dc10 = h_sl0[9:2];
        else                dc10 = 8'd128;

        if (left_av_q)      dc01 = h_sl1[9:2];
        else if (top_av_q)  dc01 = h_st0[9:2];
        else                dc01 = 8'd128;
    end

    // One prediction generator serves both the EVAL rows and the DONE output
    always_comb begin
        sel_mode = (state_q == S_DONE) ? bm_q : mode_q;
        pred_blk = '0;
        for (int unsigned r = 0; r < 8; r++) begin
            for (int unsigned c = 0; c < 8; c++) begin
                case (sel_mode)
                    2'd1:    pred_blk[64*r + 8*c +: 8] = left_q[8*r +: 8];
                    2'd2:    pred_blk[64*r + 8*c +: 8] = top_q[8*c +: 8];
                    default: begin
                        if (r < 4) pred_blk[64*r + 8*c +: 8] = (c < 4) ? dc00 : dc10;
                        else       pred_blk[64*r + 8*c +: 8] = (c < 4) ? dc01 : dc11;
                    end
                endcase
            end
        end
    end

    always_comb begin
        mb_row   = mb_q[{row_q, 6'd0} +: 64];
        pred_row = pred_blk[{row_q, 6'd0} +: 64];
        row_sum  = '0;
        pa       = '0;
        pp       = '0;
        diff     = '0;
        for (int unsigned c = 0; c < 8; c++) begin
            pa      = mb_row[8*c +: 8];
            pp      = pred_row[8*c +: 8];
            diff    = (pa > pp) ? (pa - pp) : (pp - pa);
            row_sum = row_sum + {3'b000, diff};
        end
        sad_d = acc_q + {{(SAD_W-11){1'b0}}, row_sum};
        case (mode_q)
            2'd1:    mode_avail = left_av_q;
            2'd2:    mode_avail = top_av_q;
            default: mode_avail = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mb_q        <= '0;
            top_q       <= '0;
            left_q      <= '0;
            top_av_q    <= 1'b0;
            left_av_q   <= 1'b0;
            mode_q      <= '0;
            row_q       <= '0;
            bm_q        <= '0;
            acc_q       <= '0;
            best_q      <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            pred_out_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mb_q      <= mb_in;
                        top_q     <= top_in;
                        left_q    <= left_in;
                        top_av_q  <= top_avail;
                        left_av_q <= left_avail;
                        acc_q     <= '0;
                        best_q    <= '1;
                        bm_q      <= '0;
                        mode_q    <= '0;
                        row_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    row_q <= row_q + 3'd1;
                    if (row_q == 3'd7) begin
                        acc_q <= '0;
                        // strict compare keeps the lower mode on a tie
                        if (mode_avail && (sad_d < best_q)) begin
                            best_q <= sad_d;
                            bm_q   <= mode_q;
                        end
                        if (mode_q == 2'd2) state_q <= S_DONE;
                        else                mode_q  <= mode_q + 2'd1;
                    end else begin
                        acc_q <= sad_d;
                    end
                end
                S_DONE: begin
                    pred_out_q  <= pred_blk;
                    best_mode_q <= bm_q;
                    best_sad_q  <= best_q;
                    valid_q     <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
    assign pred_out  = pred_out_q;

endmodule

// File: tb/tb_chroma8x8_intra_modesel.sv
// Self-checking bench for chroma8x8_intra_modesel: directed cases, control
// scenarios and randomized blocks against a pixel-array reference model.
module tb_chroma8x8_intra_modesel;
    localparam int unsigned SAD_W = 14;

    logic             clk = 1'b0;
    logic             reset, start, top_avail, left_avail;
    logic [511:0]     mb_in;
    logic [63:0]      top_in, left_in;
    logic             busy, valid;
    logic [1:0]       best_mode;
    logic [SAD_W-1:0] best_sad;
    logic [511:0]     pred_out;

    int n_checks = 0;
    int n_errors = 0;

    int mb [8][8];
    int top [8];
    int left [8];
    bit ta, la;
    int exp_mode, exp_sad;
    logic [511:0] exp_pred;

    chroma8x8_intra_modesel #(.SAD_W(SAD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .top_avail  (top_avail),
        .left_avail (left_avail),
        .mb_in      (mb_in),
        .top_in     (top_in),
        .left_in    (left_in),
        .busy       (busy),
        .valid      (valid),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .pred_out   (pred_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on pixel arrays
    function automatic int dc_val(int qx, int qy);
        int st = 0, sl = 0;
        for (int k = 0; k < 4; k++) begin
            st += top[4*qx + k];
            sl += left[4*qy + k];
        end
        if (qx == qy) begin
            if (ta && la) return (st + sl + 4) / 8;
            if (ta) return (st + 2) / 4;
            if (la) return (sl + 2) / 4;
            return 128;
        end else if (qx == 1) begin
            if (ta) return (st + 2) / 4;
            if (la) return (sl + 2) / 4;
            return 128;
        end else begin
            if (la) return (sl + 2) / 4;
            if (ta) return (st + 2) / 4;
            return 128;
        end
    endfunction

    function automatic int pred_of(int m, int r, int c);
        if (m == 1) return left[r];
        if (m == 2) return top[c];
        return dc_val(c / 4, r / 4);
    endfunction

    task automatic model_run();
        int s, d;
        bit avail;
        exp_sad  = 1 << 30;
        exp_mode = 0;
        for (int m = 0; m < 3; m++) begin
            avail = (m == 0) || (m == 1 && la) || (m == 2 && ta);
            s = 0;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    d = mb[r][c] - pred_of(m, r, c);
                    s += (d < 0) ? -d : d;
                end
            if (avail && s < exp_sad) begin
                exp_sad  = s;
                exp_mode = m;
            end
        end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                exp_pred[64*r + 8*c +: 8] = 8'(pred_of(exp_mode, r, c));
    endtask

    task automatic apply_inputs();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb_in[64*r + 8*c +: 8] = 8'(mb[r][c]);
        for (int j = 0; j < 8; j++) begin
            top_in[8*j +: 8]  = 8'(top[j]);
            left_in[8*j +: 8] = 8'(left[j]);
        end
        top_avail  = ta;
        left_avail = la;
    endtask

    task automatic set_all(input int mv, input int tv, input int lv, input bit t_a, input bit l_a);
        for (int r = 0; r < 8; r++) begin
            top[r]  = tv;
            left[r] = lv;
            for (int c = 0; c < 8; c++) mb[r][c] = mv;
        end
        ta = t_a;
        la = l_a;
    endtask

    // Runs one block; inputs are scrambled right after the start edge, and
    // optionally a second start is pulsed mid-EVAL with the scrambled data.
    task automatic run_case(input string tag, input bit double_start);
        int cyc;
        bit got;
        model_run();
        @(negedge clk);
        apply_inputs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        mb_in      = {16{$urandom()}};
        top_in     = {$urandom(), $urandom()};
        left_in    = {$urandom(), $urandom()};
        top_avail  = ~ta;
        left_avail = ~la;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (double_start && cyc == 4) start = 1'b1;
            if (double_start && cyc == 5) start = 1'b0;
            if (valid) got = 1'b1;
        end
        check({tag, "_latency"}, cyc, 25);
        check({tag, "_mode"}, best_mode, exp_mode);
        check({tag, "_sad"}, best_sad, exp_sad);
        check({tag, "_pred"}, pred_out, exp_pred);
        check({tag, "_busy_end"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid_pulse"}, valid, 0);
        check({tag, "_sad_hold"}, best_sad, exp_sad);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, base, v;
        reset = 1'b1;
        start = 1'b0;
        mb_in = '0;
        top_in = '0;
        left_in = '0;
        top_avail = 1'b0;
        left_avail = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_mode", best_mode, 0);
        check("rst_sad", best_sad, 0);
        check("rst_pred", pred_out, 0);
        @(negedge clk);
        reset = 1'b0;

        set_all(100, 100, 100, 1, 1);
        run_case("flat", 0);
        check("flat_sad_const", best_sad, 0);

        set_all(0, 0, 0, 1, 1);
        for (int r = 0; r < 8; r++) begin
            left[r] = 20 + 10*r;
            for (int c = 0; c < 8; c++) mb[r][c] = 20 + 10*r;
        end
        run_case("horiz", 0);
        check("horiz_mode_const", best_mode, 1);

        set_all(0, 0, 200, 1, 1);
        for (int c = 0; c < 8; c++) begin
            top[c] = 16*c;
            for (int r = 0; r < 8; r++) mb[r][c] = 16*c;
        end
        run_case("vert", 0);
        check("vert_mode_const", best_mode, 2);

        set_all(128, 7, 9, 0, 0);
        run_case("nonb128", 0);

        set_all(50, 50, 50, 1, 1);
        run_case("tie", 0);
        check("tie_mode_const", best_mode, 0);

        set_all(0, 40, 60, 1, 1);
        for (int j = 4; j < 8; j++) top[j] = 80;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mb[r][c] = (r < 4) ? ((c < 4) ? 50 : 80) : ((c < 4) ? 60 : 70);
        run_case("dcquad", 0);
        check("dcquad_sad_const", best_sad, 0);

        set_all(0, 0, 0, 1, 1);
        for (int r = 0; r < 8; r++) left[r] = 30 + r;
        for (int c = 0; c < 8; c++) top[c] = 200 - c;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mb[r][c] = 30 + r + (c % 3);
        run_case("dblstart", 1);

        set_all(0, 0, 0, 1, 1);
        for (int r = 0; r < 8; r++) left[r] = $urandom_range(0, 255);
        for (int c = 0; c < 8; c++) top[c] = $urandom_range(0, 255);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) mb[r][c] = $urandom_range(0, 255);
        run_case("rst_prev", 0);

        set_all(0, 0, 0, 0, 0);
        run_case("nonb0", 0);
        check("nonb0_sad_const", best_sad, 8192);

        // Reset in the middle of EVAL
        set_all(10, 20, 30, 1, 1);
        @(negedge clk);
        apply_inputs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_mode", best_mode, 0);
        check("abort_sad", best_sad, 0);
        check("abort_pred", pred_out, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1;
        end
        check("abort_no_valid", seen, 0);
        run_case("after_abort", 0);

        for (int it = 0; it < 20; it++) begin
            ta = 1'($urandom_range(0, 1));
            la = 1'($urandom_range(0, 1));
            for (int j = 0; j < 8; j++) begin
                top[j]  = $urandom_range(0, 255);
                left[j] = $urandom_range(0, 255);
            end
            base = $urandom_range(0, 3);
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++) begin
                    if (base == 3) v = $urandom_range(0, 255);
                    else begin
                        v = pred_of(base, r, c) + $urandom_range(0, 6) - 3;
                        if (v < 0) v = 0;
                        if (v > 255) v = 255;
                    end
                    mb[r][c] = v;
                end
            run_case($sformatf("rand%0d", it), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
